// File: rtl/regfile_rst_hi_en.sv
// Multi-port register file: two combinational read ports, one write port, optional
// write-through bypass, optional hardwired-zero register 0, and a per-register busy scoreboard.
module regfile_rst_hi_en #(
   parameter  int WIDTH    = 32,
   parameter  int DEPTH    = 32,
   parameter  int ZERO_REG = 1,
   parameter  int BYPASS   = 1,
   localparam int AW       = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr1,
   output logic [WIDTH-1:0] rdata1,
   input  logic [AW-1:0]    raddr2,
   output logic [WIDTH-1:0] rdata2,
   input  logic             mark_en,
   input  logic [AW-1:0]    mark_addr,
   output logic             busy1,
   output logic             busy2
);

   logic [WIDTH-1:0] regs [DEPTH];
   logic [DEPTH-1:0] busy;
   logic [DEPTH-1:0] busy_next;
   logic             write_ok;

   function automatic logic is_zero_reg(input logic [AW-1:0] addr);
      return (ZERO_REG != 0) && (addr == '0);
   endfunction

   // Bypass forwards wdata even while rst is high; only the stored write is discarded.
   function automatic logic [WIDTH-1:0] read_data(input logic [AW-1:0] addr);
      if (is_zero_reg(addr))
         return '0;
      else if ((BYPASS != 0) && we && (waddr == addr))
         return wdata;
      else
         return regs[addr];
   endfunction

   function automatic logic read_busy(input logic [AW-1:0] addr);
      if (is_zero_reg(addr))
         return 1'b0;
      else
         return busy[addr];
   endfunction

   assign write_ok = we && !is_zero_reg(waddr);

   // Clear on write first, then apply mark so a same-address mark wins.
   always_comb begin
      busy_next = busy;
      if (we)
         busy_next[waddr] = 1'b0;
      if (mark_en)
         busy_next[mark_addr] = 1'b1;
      if (ZERO_REG != 0)
         busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++)
            regs[i] <= '0;
         busy <= '0;
      end else begin
         if (write_ok)
            regs[waddr] <= wdata;
         busy <= busy_next;
      end
   end

   always_comb begin
      rdata1 = read_data(raddr1);
      rdata2 = read_data(raddr2);
      busy1  = read_busy(raddr1);
      busy2  = read_busy(raddr2);
   end

endmodule

// File: tb/tb_regfile_rst_hi_en.sv
// Directed bench for regfile_rst_hi_en: default build, a BYPASS=0 build and a small
// WIDTH=8/DEPTH=4/ZERO_REG=0 build, all driven from one linear stimulus sequence.
module tb_regfile_rst_hi_en;

   logic        clk = 1'b0;
   logic        rst;
   logic        we, mark_en;
   logic [4:0]  waddr, raddr1, raddr2, mark_addr;
   logic [31:0] wdata;
   logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
   logic        b1_a, b2_a, b1_b, b2_b;

   logic        we_c, mark_en_c;
   logic [1:0]  waddr_c, raddr1_c, raddr2_c, mark_addr_c;
   logic [7:0]  wdata_c, rd1_c, rd2_c;
   logic        b1_c, b2_c;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   regfile_rst_hi_en #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1), .BYPASS(1)) dut_a (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr1(raddr1), .rdata1(rd1_a), .raddr2(raddr2), .rdata2(rd2_a),
      .mark_en(mark_en), .mark_addr(mark_addr), .busy1(b1_a), .busy2(b2_a));

   regfile_rst_hi_en #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1), .BYPASS(0)) dut_b (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr1(raddr1), .rdata1(rd1_b), .raddr2(raddr2), .rdata2(rd2_b),
      .mark_en(mark_en), .mark_addr(mark_addr), .busy1(b1_b), .busy2(b2_b));

   regfile_rst_hi_en #(.WIDTH(8), .DEPTH(4), .ZERO_REG(0), .BYPASS(1)) dut_c (
      .clk(clk), .rst(rst), .we(we_c), .waddr(waddr_c), .wdata(wdata_c),
      .raddr1(raddr1_c), .rdata1(rd1_c), .raddr2(raddr2_c), .rdata2(rd2_c),
      .mark_en(mark_en_c), .mark_addr(mark_addr_c), .busy1(b1_c), .busy2(b2_c));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs are then changed 1ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
      raddr1 = 5'd5; raddr2 = 5'd0; mark_en = 1'b0; mark_addr = 5'd0;
      we_c = 1'b0; waddr_c = 2'd0; wdata_c = 8'h00; raddr1_c = 2'd0; raddr2_c = 2'd0;
      mark_en_c = 1'b0; mark_addr_c = 2'd0;
      #1;
      chk("rst_bypass_a", rd1_a, 32'hDEADBEEF);
      step();
      chk("rst_held_b_old", rd1_b, 32'h0);
      chk("rst_held_bypass_a", rd1_a, 32'hDEADBEEF);
      step();
      rst = 1'b0; we = 1'b0;
      #1;
      chk("rst_rdata1_a", rd1_a, 32'h0);
      chk("rst_rdata1_b", rd1_b, 32'h0);
      chk("rst_busy1_a", b1_a, 1'b0);
      chk("rst_busy1_b", b1_b, 1'b0);

      // Write then read back on both ports
      we = 1'b1; waddr = 5'd7; wdata = 32'h12345678; raddr1 = 5'd3; raddr2 = 5'd3;
      step();
      we = 1'b0; raddr1 = 5'd7; raddr2 = 5'd7;
      #1;
      chk("wr7_rd1_a", rd1_a, 32'h12345678);
      chk("wr7_rd2_a", rd2_a, 32'h12345678);
      chk("wr7_rd1_b", rd1_b, 32'h12345678);
      chk("wr7_rd2_b", rd2_b, 32'h12345678);

      // Same-cycle bypass vs. no-bypass build
      we = 1'b1; waddr = 5'd3; wdata = 32'hA5A5A5A5; raddr1 = 5'd3; raddr2 = 5'd7;
      #1;
      chk("byp_rd1_a", rd1_a, 32'hA5A5A5A5);
      chk("nobyp_rd1_b", rd1_b, 32'h0);
      chk("byp_other_port_a", rd2_a, 32'h12345678);
      step();
      we = 1'b0;
      #1;
      chk("nobyp_after_b", rd1_b, 32'hA5A5A5A5);

      // Register 0 ignores writes, bypass and marks
      we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; mark_en = 1'b1; mark_addr = 5'd0;
      raddr1 = 5'd0; raddr2 = 5'd0;
      #1;
      chk("zero_byp_a", rd1_a, 32'h0);
      step();
      we = 1'b0; mark_en = 1'b0;
      #1;
      chk("zero_rd1_a", rd1_a, 32'h0);
      chk("zero_busy1_a", b1_a, 1'b0);
      chk("zero_rd2_b", rd2_b, 32'h0);
      chk("zero_busy2_b", b2_b, 1'b0);

      // Scoreboard on reg 9
      mark_en = 1'b1; mark_addr = 5'd9; raddr2 = 5'd9;
      #1;
      chk("mark9_not_forwarded", b2_a, 1'b0);
      step();
      mark_en = 1'b0;
      #1;
      chk("mark9_busy2", b2_a, 1'b1);
      we = 1'b1; waddr = 5'd9; wdata = 32'h11111111;
      #1;
      chk("clr9_not_forwarded", b2_a, 1'b1);
      step();
      we = 1'b0;
      #1;
      chk("clr9_busy2", b2_a, 1'b0);
      chk("clr9_data", rd2_a, 32'h11111111);
      we = 1'b1; waddr = 5'd9; wdata = 32'h22222222; mark_en = 1'b1; mark_addr = 5'd9;
      step();
      we = 1'b0; mark_en = 1'b0;
      #1;
      chk("markwin9_busy2", b2_a, 1'b1);
      chk("markwin9_data", rd2_a, 32'h22222222);
      chk("markwin9_busy2_b", b2_b, 1'b1);
      raddr1 = 5'd9;
      #1;
      chk("same_addr_busy", b1_a, b2_a);
      chk("same_addr_data", rd1_a, 32'h22222222);

      // Mark 4 and write 9 in one edge
      we = 1'b1; waddr = 5'd9; wdata = 32'h33333333; mark_en = 1'b1; mark_addr = 5'd4;
      raddr1 = 5'd4; raddr2 = 5'd9;
      step();
      we = 1'b0; mark_en = 1'b0;
      #1;
      chk("split_busy4", b1_a, 1'b1);
      chk("split_busy9", b2_a, 1'b0);
      chk("split_data9", rd2_a, 32'h33333333);

      // Mid-operation reset drops data and busy state
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      chk("midrst_busy4", b1_a, 1'b0);
      chk("midrst_data9", rd2_a, 32'h0);
      we = 1'b1; waddr = 5'd2; wdata = 32'h0BADF00D; mark_en = 1'b1; mark_addr = 5'd4;
      raddr1 = 5'd2; raddr2 = 5'd4;
      step();
      we = 1'b0; mark_en = 1'b0;
      #1;
      chk("postrst_wr2_b", rd1_b, 32'h0BADF00D);
      chk("postrst_busy4", b2_a, 1'b1);

      // Small build without a zero register
      for (int i = 0; i < 4; i++) begin
         we_c = 1'b1; waddr_c = 2'(i); wdata_c = 8'h3C + 8'(i * 8'h11);
         step();
      end
      we_c = 1'b0;
      raddr1_c = 2'd0; raddr2_c = 2'd1;
      #1;
      chk("c_rd_r0", rd1_c, 8'h3C);
      chk("c_rd_r1", rd2_c, 8'h4D);
      raddr1_c = 2'd2; raddr2_c = 2'd3;
      #1;
      chk("c_rd_r2", rd1_c, 8'h5E);
      chk("c_rd_r3", rd2_c, 8'h6F);
      mark_en_c = 1'b1; mark_addr_c = 2'd0; raddr1_c = 2'd0;
      step();
      mark_en_c = 1'b0;
      #1;
      chk("c_busy_r0", b1_c, 1'b1);
      we_c = 1'b1; waddr_c = 2'd0; wdata_c = 8'hC3;
      #1;
      chk("c_byp_r0", rd1_c, 8'hC3);
      step();
      we_c = 1'b0;
      #1;
      chk("c_wr_r0", rd1_c, 8'hC3);
      chk("c_clr_r0", b1_c, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_rst_hi_en.md
REGFILE_RST_HI_EN -- requirements
Module: regfile_rst_hi_en

Interface
REQ-001 Parameter WIDTH, default 32: data width of every register, read data and write data.
REQ-002 Parameter DEPTH, default 32: number of registers, power of two, minimum 2; AW = $clog2(DEPTH) is derived, not a parameter.
REQ-003 Parameter ZERO_REG, default 1: 1 makes register 0 read as zero, ignore writes and never become busy.
REQ-004 Parameter BYPASS, default 1: 1 makes a same-cycle write visible on read ports (write-through).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous reset, active-high.
REQ-007 we  input  1  write enable.
REQ-008 waddr  input  AW  write address.
REQ-009 wdata  input  WIDTH  write data.
REQ-010 raddr1  input  AW  read port 1 address.
REQ-011 rdata1  output  WIDTH  read port 1 data.
REQ-012 raddr2  input  AW  read port 2 address.
REQ-013 rdata2  output  WIDTH  read port 2 data.
REQ-014 mark_en  input  1  set busy bit of mark_addr (producer issued).
REQ-015 mark_addr  input  AW  register to mark busy.
REQ-016 busy1  output  1  busy bit of raddr1.
REQ-017 busy2  output  1  busy bit of raddr2.

Function
REQ-018 Storage SHALL be DEPTH registers of WIDTH bits plus DEPTH busy bits, all flip-flops updated only on rising clk.
REQ-019 Write: with we=1 and rst=0, reg[waddr] SHALL take wdata at the rising edge; we=0 SHALL leave all registers unchanged.
REQ-020 Reads SHALL be combinational: rdataN = reg[raddrN] with zero added cycles of latency.
REQ-021 BYPASS=1: when we=1 and waddr==raddrN, rdataN SHALL equal wdata in the same cycle; BYPASS=0: rdataN SHALL show the old value until after the edge.
REQ-022 ZERO_REG=1: address 0 SHALL read 0 on both ports regardless of writes or bypass; writes to 0 SHALL be dropped.
REQ-023 Busy set: mark_en=1 SHALL set busy[mark_addr] at the rising edge.
REQ-024 Busy clear: we=1 SHALL clear busy[waddr] at the rising edge.
REQ-025 mark_en and we to the same address in one cycle: data SHALL be written and busy SHALL end set (mark wins).
REQ-026 mark_en and we to different addresses: both updates SHALL occur in the same edge.
REQ-027 busyN SHALL reflect the registered busy bit only (no bypass of the same-cycle mark or clear).
REQ-028 ZERO_REG=1: busy[0] SHALL stay 0; busy1/busy2 for address 0 SHALL read 0.
REQ-029 Both read ports SHALL be independent; identical addresses on both ports SHALL return identical data and busy.

Reset
REQ-030 rst=1 at a rising edge SHALL clear every register to 0 and every busy bit to 0, overriding we and mark_en.
REQ-031 During rst=1, reads SHALL remain combinational; BYPASS SHALL still forward wdata when we=1 (write itself discarded).
REQ-032 Reset asserted mid-operation SHALL discard all pending busy state; first edge after rst falls SHALL behave as normal operation.

Verification
REQ-033 Reset: hold rst=1 two cycles with we=1, waddr=5, wdata=32'hDEADBEEF -> after release, rdata1 (raddr1=5)=0, busy1=0.
REQ-034 Write/read: write 32'h12345678 to reg 7, next cycle raddr1=7, raddr2=7 -> both rdata = 32'h12345678.
REQ-035 Bypass: BYPASS=1, we=1, waddr=3, wdata=32'hA5A5A5A5, raddr1=3 same cycle -> rdata1=32'hA5A5A5A5; BYPASS=0 build -> old value 0.
REQ-036 Zero register: write 32'hFFFFFFFF and mark_en to address 0 -> rdata1=0, busy1=0 after the edge.
REQ-037 Scoreboard: mark_en reg 9 -> busy2=1 next cycle; we to reg 9 -> busy2=0 next cycle; simultaneous mark+write to 9 -> busy2=1, data updated.
REQ-038 Parameter sweep: WIDTH=8, DEPTH=4, ZERO_REG=0 -> write 8'h3C to reg 0 reads back 8'h3C, all four registers independently writable.
